// File: rtl/to_int_arbiter_pkg.sv
// Shared constants, tag bundle and float->int32 helper for to_int_arbiter.
// TO_INT_OVF_FLAG_EN adds an overflow bit to the tag and response slots.
package to_int_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int TO_INT_LATENCY = 2;
  localparam int TAG_ID_W = 3;

  localparam logic [31:0] INT_MIN_SAT = 32'h8000_0000;
  localparam logic [7:0] OVF_EXP_THRESH = 8'd158;
  localparam logic [7:0] EXP_BIAS = 8'd127;
  // exponent at which the mantissa lsb has weight 1
  localparam logic [7:0] EXP_UNIT = 8'd150;

  typedef struct packed {
    logic valid;
    logic [TAG_ID_W-1:0] id;
`ifdef TO_INT_OVF_FLAG_EN
    logic ovf;
`endif
  } tag_t;

  function automatic logic [31:0] f32_to_i32(
    input logic [31:0] a
  );
    logic [7:0] e;
    logic [31:0] mag;
    logic [31:0] r;
    e = a[30:23];
    mag = {8'd0, 1'b1, a[22:0]};
    if (e >= EXP_UNIT) mag = mag << (e - EXP_UNIT);
    else mag = mag >> (EXP_UNIT - e);
    if (e >= OVF_EXP_THRESH) r = INT_MIN_SAT;
    else if (e < EXP_BIAS) r = '0;
    else r = a[31] ? (~mag + 32'd1) : mag;
    return r;
  endfunction

endpackage

// File: rtl/to_int_arbiter_if.sv
// Requester-side request/response bundle for to_int_arbiter.
// rsp_ovf exists only when TO_INT_OVF_FLAG_EN is defined.
interface to_int_arbiter_if
  import to_int_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [DATA_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0] rsp_valid;
  logic [N_REQ-1:0] rsp_ready;
  logic [DATA_W*N_REQ-1:0] rsp_data;
`ifdef TO_INT_OVF_FLAG_EN
  logic [N_REQ-1:0] rsp_ovf;

  modport master (
    output req_valid, req_data, rsp_ready,
    input req_ready, rsp_valid, rsp_data, rsp_ovf
  );
  modport slave (
    input req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_ovf
  );
`else
  modport master (
    output req_valid, req_data, rsp_ready,
    input req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
`endif
endinterface

// File: rtl/to_int.sv
// Fixed-latency float32 -> int32 truncating converter.
// No reset, stall or valid: the caller tracks what is in flight.
module to_int
  import to_int_arbiter_pkg::*;
#(
  parameter int LATENCY = TO_INT_LATENCY
) (
  input  logic        clk,
  input  logic [31:0] a,
  output logic [31:0] z
);
  logic [31:0] pipe_q [LATENCY];
  logic [31:0] pipe_d [LATENCY];

  always_comb begin
    pipe_d[0] = f32_to_i32(a);
    for (int s = 1; s < LATENCY; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < LATENCY; s++) begin
      pipe_q[s] <= pipe_d[s];
    end
  end

  assign z = pipe_q[LATENCY-1];

endmodule

// File: rtl/to_int_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping.
// Grant is one-hot; idx is its encoded position.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         found
);
  always_comb begin
    int c;
    logic [W-1:0] cw;
    gnt = '0;
    idx = '0;
    found = 1'b0;
    c = 0;
    cw = '0;
    for (int o = 0; o < N; o++) begin
      c = int'(ptr) + o;
      if (c >= N) c = c - N;
      cw = W'(c);
      if (!found && req[cw]) begin
        found = 1'b1;
        gnt[cw] = 1'b1;
        idx = cw;
      end
    end
  end

endmodule

// File: rtl/to_int_arbiter.sv
// Shares one to_int pipeline between N_REQ requesters with a matched tag pipe.
// TO_INT_OVF_FLAG_EN adds a per-requester overflow flag (rsp_ovf).
module to_int_arbiter
  import to_int_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W = 2,
  parameter int LATENCY = TO_INT_LATENCY
) (
  input logic clk,
  input logic rst,
  to_int_arbiter_if.slave bus
);
  logic [N_REQ-1:0] inflight_q, inflight_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [N_REQ-1:0][DATA_W-1:0] rsp_data_q;
  logic [N_REQ-1:0][DATA_W-1:0] rsp_data_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  tag_t tag_q [LATENCY];
  tag_t tag_d [LATENCY];
  tag_t last;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0] gnt_idx;
  logic gnt_any;
  logic [N_REQ-1:0][DATA_W-1:0] req_data_v;
  logic [DATA_W-1:0] cvt_a, cvt_z;

`ifdef TO_INT_OVF_FLAG_EN
  logic [N_REQ-1:0] rsp_ovf_q, rsp_ovf_d;
  assign bus.rsp_ovf = rsp_ovf_q;
`endif

  // a requester with an op in flight or an unread result is blocked
  assign eligible = bus.req_valid
                  & ~(inflight_q | rsp_valid_q)
                  & {N_REQ{~rst}};

  rr_arbiter #(
    .N(N_REQ),
    .W(ID_W)
  ) u_rr (
    .req(eligible),
    .ptr(ptr_q),
    .gnt(gnt),
    .idx(gnt_idx),
    .found(gnt_any)
  );

  assign req_data_v = bus.req_data;
  assign cvt_a = req_data_v[gnt_idx];

  to_int #(
    .LATENCY(LATENCY)
  ) u_cvt (
    .clk(clk),
    .a(cvt_a),
    .z(cvt_z)
  );

  assign last = tag_q[LATENCY-1];
  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data = rsp_data_q;

  always_comb begin
    ptr_d = ptr_q;
    inflight_d = inflight_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d = rsp_data_q;
`ifdef TO_INT_OVF_FLAG_EN
    rsp_ovf_d = rsp_ovf_q;
`endif
    tag_d[0] = '0;
    for (int s = 1; s < LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end

    if (gnt_any) begin
      ptr_d = (gnt_idx == ID_W'(N_REQ-1))
            ? '0 : gnt_idx + 1'b1;
      tag_d[0].valid = 1'b1;
      tag_d[0].id = TAG_ID_W'(gnt_idx);
`ifdef TO_INT_OVF_FLAG_EN
      tag_d[0].ovf = cvt_a[30:23] >= OVF_EXP_THRESH;
`endif
    end

    for (int k = 0; k < N_REQ; k++) begin
      if (rsp_valid_q[k] && bus.rsp_ready[k]) begin
        rsp_valid_d[k] = 1'b0;
      end
      if (gnt[k]) begin
        inflight_d[k] = 1'b1;
      end
      if (last.valid && last.id == TAG_ID_W'(k)) begin
        rsp_valid_d[k] = 1'b1;
        rsp_data_d[k] = cvt_z;
        inflight_d[k] = 1'b0;
`ifdef TO_INT_OVF_FLAG_EN
        rsp_ovf_d[k] = last.ovf;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      inflight_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
`ifdef TO_INT_OVF_FLAG_EN
      rsp_ovf_q <= '0;
`endif
      for (int s = 0; s < LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      inflight_q <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
`ifdef TO_INT_OVF_FLAG_EN
      rsp_ovf_q <= rsp_ovf_d;
`endif
      for (int s = 0; s < LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

endmodule

// File: tb/tb_to_int_arbiter.sv
// Bench for to_int_arbiter: vector table, directed sequences, random traffic.
// Overflow flag checks apply when TO_INT_OVF_FLAG_EN is defined.
module tb_to_int_arbiter;
  import to_int_arbiter_pkg::*;

  localparam int N = 4;
  localparam int LAT = 2;
  localparam int NV = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  to_int_arbiter_if #(.N_REQ(N)) bus();

  to_int_arbiter #(
    .N_REQ(N),
    .ID_W(2),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [N-1:0] ovf_s;
`ifdef TO_INT_OVF_FLAG_EN
  assign ovf_s = bus.rsp_ovf;
`else
  assign ovf_s = '0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] z;
    logic ovf;
  } vec_t;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(
    input logic [32*N-1:0] v, input int r);
    return v[32*r +: 32];
  endfunction

  task automatic set_data(input int r, input logic [31:0] v);
    bus.req_data[32*r +: 32] = v;
  endtask

  // value = 1.m * 2^(e-127), truncated toward zero
  function automatic logic [31:0] ref_cvt(input logic [31:0] a);
    int e;
    real v;
    longint m;
    e = int'(a[30:23]);
    if (e >= 158) return 32'h8000_0000;
    if (e < 127) return 32'h0;
    v = 1.0 + real'(int'(a[22:0])) / 8388608.0;
    for (int i = 127; i < e; i++) v = v * 2.0;
    m = longint'($floor(v));
    if (a[31]) m = -m;
    return m[31:0];
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    f = $urandom;
    if ($urandom_range(0, 15) != 0) begin
      f[30:23] = 8'($urandom_range(118, 162));
    end
    return f;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = '0;
    #1 chk("rst_ready", 64'(bus.req_ready), 0);
    @(negedge clk);
    #1 chk("rst_ready_hold", 64'(bus.req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    #1 chk("rst_rspv", 64'(bus.rsp_valid), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vt [NV];
    logic [31:0] seq_ops [N];
    logic [31:0] w;
    logic [32:0] ent;
    logic [N-1:0] expg, expv;
    logic [32:0] expq [N][$];
    bit out_m [N];
    int gcyc [N];
    int ptr_m, k, r;
    bit found;

    vt[0]  = '{32'h3F80_0000, 32'h0000_0001, 1'b0};
    vt[1]  = '{32'hC020_0000, 32'hFFFF_FFFE, 1'b0};
    vt[2]  = '{32'h4F00_0000, 32'h8000_0000, 1'b1};
    vt[3]  = '{32'h7FC0_0000, 32'h8000_0000, 1'b1};
    vt[4]  = '{32'h3F00_0000, 32'h0000_0000, 1'b0};
    vt[5]  = '{32'hCF00_0000, 32'h8000_0000, 1'b1};
    vt[6]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0};
    vt[7]  = '{32'h0000_0001, 32'h0000_0000, 1'b0};
    vt[8]  = '{32'h8000_0000, 32'h0000_0000, 1'b0};
    vt[9]  = '{32'hBF7F_FFFF, 32'h0000_0000, 1'b0};
    vt[10] = '{32'h7F80_0000, 32'h8000_0000, 1'b1};
    vt[11] = '{32'hC2C8_0000, 32'hFFFF_FF9C, 1'b0};
    vt[12] = '{32'h4B00_0001, 32'h0080_0001, 1'b0};
    vt[13] = '{32'h4049_0FDB, 32'h0000_0003, 1'b0};

    seq_ops[0] = 32'h3F80_0000;
    seq_ops[1] = 32'h4000_0000;
    seq_ops[2] = 32'h4040_0000;
    seq_ops[3] = 32'h4080_0000;

    bus.req_valid = '0;
    bus.req_data = '0;
    bus.rsp_ready = '0;
    do_reset();

    // all four continuously valid: 0,1,2,3,0,1,2,3
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        for (int i = 0; i < N; i++) set_data(i, seq_ops[i]);
        bus.rsp_ready = '1;
        bus.req_valid = '1;
      end
      #1;
      chk("rr_gnt", 64'(bus.req_ready), 64'(1 << (c % 4)));
      if (c >= 3) begin
        chk("rr_rspv", 64'(bus.rsp_valid),
            64'(1 << ((c - 3) % 4)));
        chk("rr_data", 64'(word(bus.rsp_data, (c - 3) % 4)),
            64'((c - 3) % 4 + 1));
      end else begin
        chk("rr_rspv_early", 64'(bus.rsp_valid), 0);
      end
    end
    @(negedge clk);
    bus.req_valid = '0;
    repeat (5) @(negedge clk);

    // single-op vector table
    for (int v = 0; v < NV; v++) begin
      r = v % N;
      @(negedge clk);
      set_data(r, vt[v].a);
      bus.req_valid = N'(1 << r);
      #1 chk("vec_gnt", 64'(bus.req_ready), 64'(1 << r));
      @(negedge clk);
      bus.req_valid = '0;
      #1 chk("vec_lat1", 64'(bus.rsp_valid), 0);
      @(negedge clk);
      #1 chk("vec_lat2", 64'(bus.rsp_valid), 0);
      @(negedge clk);
      #1 chk("vec_rspv", 64'(bus.rsp_valid), 64'(1 << r));
      chk("vec_data", 64'(word(bus.rsp_data, r)), 64'(vt[v].z));
`ifdef TO_INT_OVF_FLAG_EN
      chk("vec_ovf", 64'(ovf_s[r]), 64'(vt[v].ovf));
`endif
      @(negedge clk);
      #1 chk("vec_clr", 64'(bus.rsp_valid), 0);
    end

    // req2 result held while rsp_ready[2] is low
    @(negedge clk);
    bus.rsp_ready = 4'b1011;
    set_data(2, 32'hC020_0000);
    bus.req_valid = 4'b0100;
    #1 chk("hold_gnt", 64'(bus.req_ready), 64'h4);
    @(negedge clk);
    set_data(2, 32'h40A0_0000);
    #1 chk("hold_busy1", 64'(bus.req_ready), 0);
    @(negedge clk);
    #1 chk("hold_busy2", 64'(bus.req_ready), 0);
    for (int h = 0; h < 10; h++) begin
      @(negedge clk);
      #1;
      chk("hold_v", 64'(bus.rsp_valid), 64'h4);
      chk("hold_data", 64'(word(bus.rsp_data, 2)),
          64'hFFFF_FFFE);
      chk("hold_nogrant", 64'(bus.req_ready), 0);
    end
    @(negedge clk);
    bus.rsp_ready = '1;
    #1 chk("hold_hs_nogrant", 64'(bus.req_ready), 0);
    @(negedge clk);
    #1 chk("hold_regrant", 64'(bus.req_ready), 64'h4);
    chk("hold_clr", 64'(bus.rsp_valid), 0);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("hold_next_v", 64'(bus.rsp_valid), 64'h4);
    chk("hold_next_data", 64'(word(bus.rsp_data, 2)), 64'd5);
    @(negedge clk);

    // reset with three ops in flight
    bus.rsp_ready = '0;
    set_data(0, 32'h4120_0000);
    set_data(1, 32'h41A0_0000);
    set_data(2, 32'h4120_0000);
    bus.req_valid = 4'b0111;
    #1 chk("mid_g0", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    #1 chk("mid_g1", 64'(bus.req_ready), 64'h2);
    @(negedge clk);
    #1 chk("mid_g2", 64'(bus.req_ready), 64'h4);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_rst_ready", 64'(bus.req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    for (int s = 0; s < 6; s++) begin
      #1 chk("mid_stale", 64'(bus.rsp_valid), 0);
      @(negedge clk);
    end
    bus.rsp_ready = '1;
    set_data(0, 32'h4228_0000);
    bus.req_valid = '1;
    #1 chk("mid_ptr0", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("mid_next_v", 64'(bus.rsp_valid), 64'h1);
    chk("mid_next_data", 64'(word(bus.rsp_data, 0)), 64'd42);
    @(negedge clk);

    // random traffic against the reference model
    do_reset();
    ptr_m = 0;
    for (int i = 0; i < N; i++) begin
      out_m[i] = 1'b0;
      gcyc[i] = 0;
      expq[i].delete();
    end
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (c < 9990) begin
        bus.req_valid = N'($urandom);
        bus.rsp_ready = N'($urandom | $urandom);
      end else begin
        bus.req_valid = '0;
        bus.rsp_ready = '1;
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) set_data(i, rand_float());
      end
      #1;
      expg = '0;
      found = 1'b0;
      k = 0;
      for (int o = 0; o < N; o++) begin
        r = (ptr_m + o) % N;
        if (!found && bus.req_valid[r] && !out_m[r]) begin
          found = 1'b1;
          k = r;
          expg[r] = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        expv[i] = out_m[i] && (c >= gcyc[i] + LAT + 1);
      end
      chk("rnd_onehot", 64'($countones(bus.req_ready) <= 1), 1);
      chk("rnd_gnt", 64'(bus.req_ready), 64'(expg));
      chk("rnd_rspv", 64'(bus.rsp_valid), 64'(expv));
      for (int i = 0; i < N; i++) begin
        if (expv[i]) begin
          ent = expq[i][0];
          w = word(bus.rsp_data, i);
`ifdef TO_INT_OVF_FLAG_EN
          chk("rnd_data", 64'({ovf_s[i], w}), 64'(ent));
`else
          chk("rnd_data", 64'(w), 64'(ent[31:0]));
`endif
          if (bus.rsp_ready[i]) begin
            void'(expq[i].pop_front());
            out_m[i] = 1'b0;
          end
        end
      end
      if (found) begin
        w = word(bus.req_data, k);
        expq[k].push_back({w[30:23] >= 8'd158, ref_cvt(w)});
        out_m[k] = 1'b1;
        gcyc[k] = c;
        ptr_m = (k + 1) % N;
      end
    end
    @(negedge clk);
    #1 chk("rnd_drained", 64'(bus.rsp_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
